// File: rtl/brg_xcel_mem_responder_if.sv
// ---------------------------------------------------------------------------
// brg_xcel_mem_responder_if
//   Request/response bundle between an accelerator memory port and the
//   memory responder.
//
//   Request channel  : req_v_i, req_type_i (1 = store, 0 = load), req_addr_i
//                      (byte address), req_data_i, req_mask_i (byte enables),
//                      req_opq_i (load tag), req_ready_o.
//   Response channel : resp_v_o, resp_data_o, resp_opq_o. There is no
//                      response ready because the consumer always accepts.
//
//   The _i/_o suffixes are named from the responder's point of view.
//   master : requester side (drives the request, consumes the response).
//   slave  : responder side.
// ---------------------------------------------------------------------------
interface brg_xcel_mem_responder_if #(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned addr_width_p    = 32,
  parameter int unsigned load_id_width_p = 11
);

  logic                          req_v_i;
  logic                          req_type_i;
  logic [addr_width_p-1:0]       req_addr_i;
  logic [data_width_p-1:0]       req_data_i;
  logic [data_width_p/8-1:0]     req_mask_i;
  logic [load_id_width_p-1:0]    req_opq_i;
  logic                          req_ready_o;

  logic                          resp_v_o;
  logic [data_width_p-1:0]       resp_data_o;
  logic [load_id_width_p-1:0]    resp_opq_o;

  modport master (
    output req_v_i,
    output req_type_i,
    output req_addr_i,
    output req_data_i,
    output req_mask_i,
    output req_opq_i,
    input  req_ready_o,
    input  resp_v_o,
    input  resp_data_o,
    input  resp_opq_o
  );

  modport slave (
    input  req_v_i,
    input  req_type_i,
    input  req_addr_i,
    input  req_data_i,
    input  req_mask_i,
    input  req_opq_i,
    output req_ready_o,
    output resp_v_o,
    output resp_data_o,
    output resp_opq_o
  );

endinterface

// File: rtl/brg_xcel_mem_responder.sv
// ---------------------------------------------------------------------------
// brg_xcel_mem_responder
//   Word-addressed backing memory for an accelerator port. Stores are
//   byte-masked and produce no response. Loads read the array in their
//   acceptance cycle and return data plus the captured tag exactly latency_p
//   cycles later, in acceptance order. At most max_inflight_p loads may be
//   outstanding. Out-of-range stores are dropped, out-of-range loads return
//   32'hDEADBEEF, and either sets a sticky error flag.
//
//   Ports
//     clk_i          : clock, all state updates on the rising edge
//     reset_i        : synchronous, active-high reset
//     bus            : request/response bundle (slave side)
//     err_o          : sticky out-of-range flag
//     load_count_o   : accepted loads, wraps at 2^32
//     store_count_o  : accepted stores, wraps at 2^32
//
//   The memory array itself is never reset.
// ---------------------------------------------------------------------------
module brg_xcel_mem_responder #(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned addr_width_p    = 32,
  parameter int unsigned load_id_width_p = 11,
  parameter int unsigned mem_els_p       = 1024,
  parameter int unsigned latency_p       = 4,
  parameter int unsigned max_inflight_p  = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  brg_xcel_mem_responder_if.slave   bus,
  output logic                      err_o,
  output logic [31:0]               load_count_o,
  output logic [31:0]               store_count_o
);

  localparam int unsigned BYTES_LP  = data_width_p / 8;
  localparam int unsigned IDX_W_LP  = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int unsigned INFL_W_LP = $clog2(max_inflight_p + 1);
  localparam int unsigned LAST_LP   = latency_p - 1;
  localparam logic [31:0] OOR_WORD  = 32'hDEADBEEF;

  // Elaboration-time parameter sanity
  if (latency_p < 1) begin : g_bad_latency
    $error("brg_xcel_mem_responder: latency_p must be >= 1");
  end
  if (max_inflight_p < 1) begin : g_bad_inflight
    $error("brg_xcel_mem_responder: max_inflight_p must be >= 1");
  end
  if ((data_width_p % 8) != 0) begin : g_bad_width
    $error("brg_xcel_mem_responder: data_width_p must be a multiple of 8");
  end

  // Backing storage
  logic [data_width_p-1:0] mem_q [mem_els_p];

  // Request decode
  logic [addr_width_p-1:0] word_idx;
  logic [IDX_W_LP-1:0]     mem_idx;
  logic                    in_range;
  logic                    ready_c;
  logic                    accept;
  logic                    ld_acc;
  logic                    st_acc;
  logic [data_width_p-1:0] rd_data;

  // Load return pipeline: stage k holds a load accepted k+1 cycles ago
  logic [latency_p-1:0]                      pipe_v_q,    pipe_v_d;
  logic [latency_p-1:0][data_width_p-1:0]    pipe_data_q, pipe_data_d;
  logic [latency_p-1:0][load_id_width_p-1:0] pipe_opq_q,  pipe_opq_d;

  // Bookkeeping
  logic [INFL_W_LP-1:0] inflight_q, inflight_d;
  logic                 err_q,      err_d;
  logic [31:0]          ld_cnt_q,   ld_cnt_d;
  logic [31:0]          st_cnt_q,   st_cnt_d;
  logic                 resp_fire;

  // Byte address to word index; low two address bits are ignored
  assign word_idx = bus.req_addr_i >> 2;
  assign mem_idx  = IDX_W_LP'(word_idx);
  assign in_range = 64'(word_idx) < 64'(mem_els_p);

  // Ready depends only on registered occupancy and reset, never on req_v_i
  assign ready_c = ~reset_i & (inflight_q < INFL_W_LP'(max_inflight_p));
  assign accept  = bus.req_v_i & ready_c;
  assign ld_acc  = accept & ~bus.req_type_i;
  assign st_acc  = accept &  bus.req_type_i;

  // Loads see every store accepted in an earlier cycle; only one request
  // per cycle, so there is no same-cycle store to forward
  assign rd_data = in_range ? mem_q[mem_idx] : data_width_p'(OOR_WORD);

  assign resp_fire = pipe_v_q[LAST_LP];

  // Byte-masked store into the array
  always_ff @(posedge clk_i) begin
    if (st_acc && in_range) begin
      for (int b = 0; b < int'(BYTES_LP); b++) begin
        if (bus.req_mask_i[b]) begin
          mem_q[mem_idx][b*8 +: 8] <= bus.req_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Next-state logic for pipeline and bookkeeping
  always_comb begin
    pipe_v_d    = pipe_v_q;
    pipe_data_d = pipe_data_q;
    pipe_opq_d  = pipe_opq_q;
    inflight_d  = inflight_q;
    err_d       = err_q;
    ld_cnt_d    = ld_cnt_q;
    st_cnt_d    = st_cnt_q;

    // Stage 0 captures the load; payload registers only move behind a valid
    // so the final stage keeps its last driven value during bubbles
    pipe_v_d[0] = ld_acc;
    if (ld_acc) begin
      pipe_data_d[0] = rd_data;
      pipe_opq_d[0]  = bus.req_opq_i;
    end
    for (int k = 1; k < int'(latency_p); k++) begin
      pipe_v_d[k] = pipe_v_q[k-1];
      if (pipe_v_q[k-1]) begin
        pipe_data_d[k] = pipe_data_q[k-1];
        pipe_opq_d[k]  = pipe_opq_q[k-1];
      end
    end

    // Simultaneous accept and response leaves occupancy unchanged
    inflight_d = inflight_q + INFL_W_LP'(ld_acc) - INFL_W_LP'(resp_fire);

    err_d    = err_q | (accept & ~in_range);
    ld_cnt_d = ld_cnt_q + 32'(ld_acc);
    st_cnt_d = st_cnt_q + 32'(st_acc);
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pipe_v_q   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      ld_cnt_q   <= '0;
      st_cnt_q   <= '0;
    end else begin
      pipe_v_q   <= pipe_v_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      ld_cnt_q   <= ld_cnt_d;
      st_cnt_q   <= st_cnt_d;
    end
  end

  // Payload registers need no reset; their valids gate them
  always_ff @(posedge clk_i) begin
    pipe_data_q <= pipe_data_d;
    pipe_opq_q  <= pipe_opq_d;
  end

  // Outputs are forced quiet for the whole time reset_i is high, including
  // the first reset cycle before the synchronous clear has taken effect
  assign bus.req_ready_o = ready_c;
  assign bus.resp_v_o    = resp_fire & ~reset_i;
  assign bus.resp_data_o = pipe_data_q[LAST_LP];
  assign bus.resp_opq_o  = pipe_opq_q[LAST_LP];
  assign err_o           = err_q & ~reset_i;
  assign load_count_o    = reset_i ? '0 : ld_cnt_q;
  assign store_count_o   = reset_i ? '0 : st_cnt_q;

endmodule
